alu_sequencer: RTL and testbench

Multi-cycle command sequencer directly upstream of the 16-bit ALU datapath. Accepts one operation per valid/ready handshake, drives the ALU's operand buses and control strobes (operand-A register load, add/subtract, XOR select, multiplier output select, accumulator load), then captures the accumulator outputs into a held result that is returned over a second valid/ready handshake. Only one operation is in flight at a time.

---
 rtl/alu_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command sequencer driving the 16-bit ALU: LOAD -> EXEC -> CAPT -> HOLD per accepted op.
// Optional operand chaining from the last retired result is enabled by defining ALU_SEQ_CHAIN_EN.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_a_enable,
    output logic        alu_addsub,
    output logic        alu_xor_ctrl,
    output logic        alu_mul_out_ctrl,
    output logic        alu_acc_enable,
    input  logic [15:0] alu_acc_out,
    input  logic [15:0] alu_mul_acc_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_lo,
    output logic [15:0] res_hi
);

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, CAPT, HOLD} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_XOR, OP_MUL} op_t;

    state_t      state, state_next;
    op_t         op_q;
    logic [15:0] a_q, b_q;
    logic [15:0] a_sel;
    logic        accept, retire;

    assign accept = cmd_valid && (state == IDLE);
    assign retire = res_ready && (state == HOLD);

`ifdef ALU_SEQ_CHAIN_EN
    logic [15:0] chain_q;

    assign a_sel = cmd_op[2] ? chain_q : cmd_a;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_q <= '0;
        end else if (retire) begin
            chain_q <= res_lo;
        end
    end
`else
    logic unused_chain_flag;

    assign unused_chain_flag = cmd_op[2];
    assign a_sel             = cmd_a;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            res_lo <= '0;
            res_hi <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q <= op_t'(cmd_op[1:0]);
                a_q  <= a_sel;
                b_q  <= cmd_b;
            end
            if (state == CAPT) begin
                res_lo <= alu_acc_out;
                res_hi <= (op_q == OP_MUL) ? alu_mul_acc_out : '0;
            end
        end
    end

    // Operand buses come straight from the latched registers so they never drop to 0 between states.
    assign alu_a = a_q;
    assign alu_b = b_q;

    always_comb begin
        state_next       = state;
        cmd_ready        = 1'b0;
        res_valid        = 1'b0;
        alu_a_enable     = 1'b0;
        alu_acc_enable   = 1'b0;
        alu_addsub       = 1'b0;
        alu_xor_ctrl     = 1'b0;
        alu_mul_out_ctrl = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = LOAD;
            end
            LOAD: begin
                alu_a_enable = 1'b1;
                state_next   = EXEC;
            end
            EXEC: begin
                alu_acc_enable   = 1'b1;
                alu_addsub       = (op_q == OP_SUB);
                alu_xor_ctrl     = (op_q == OP_XOR);
                alu_mul_out_ctrl = (op_q == OP_MUL);
                state_next       = CAPT;
            end
            CAPT: begin
                state_next = HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU drives the accumulator inputs and a
// reference model derives expected results from op/operands; covers ALU_SEQ_CHAIN_EN when defined.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_a, cmd_b;
    logic [15:0] alu_a, alu_b;
    logic        alu_a_enable, alu_addsub, alu_xor_ctrl, alu_mul_out_ctrl, alu_acc_enable;
    logic [15:0] alu_acc_out, alu_mul_acc_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_lo, res_hi;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ALU_SEQ_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    alu_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_a            (cmd_a),
        .cmd_b            (cmd_b),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_a_enable     (alu_a_enable),
        .alu_addsub       (alu_addsub),
        .alu_xor_ctrl     (alu_xor_ctrl),
        .alu_mul_out_ctrl (alu_mul_out_ctrl),
        .alu_acc_enable   (alu_acc_enable),
        .alu_acc_out      (alu_acc_out),
        .alu_mul_acc_out  (alu_mul_acc_out),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_lo           (res_lo),
        .res_hi           (res_hi)
    );

    always #5 clk = ~clk;

    logic [6:0] flags;
    assign flags = {cmd_ready, res_valid, alu_a_enable, alu_acc_enable,
                    alu_addsub, alu_xor_ctrl, alu_mul_out_ctrl};

    // Behavioural ALU: operand-A register plus accumulators; multiplier-high word is junk unless MUL.
    logic [15:0] alu_areg = '0;
    always @(posedge clk) begin
        logic [31:0] p;
        if (alu_a_enable) alu_areg <= alu_a;
        if (alu_acc_enable) begin
            p = {16'h0, alu_areg} * {16'h0, alu_b};
            if (alu_mul_out_ctrl) begin
                alu_acc_out     <= p[15:0];
                alu_mul_acc_out <= p[31:16];
            end else begin
                alu_mul_acc_out <= 16'($urandom) | 16'h0001;
                if (alu_xor_ctrl)    alu_acc_out <= alu_areg ^ alu_b;
                else if (alu_addsub) alu_acc_out <= alu_areg - alu_b;
                else                 alu_acc_out <= alu_areg + alu_b;
            end
        end
    end

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (op)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a ^ b;
            default: return {16'h0, a} * {16'h0, b};
        endcase
        return {16'h0, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one command starting from an IDLE negedge; returns at the negedge after retirement.
    task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_a, input int hold,
                         input logic [15:0] exp_lo, input logic [15:0] exp_hi);
        logic [6:0] exp_exec;
        exp_exec = {4'b0001, op[1:0] == 2'd1, op[1:0] == 2'd2, op[1:0] == 2'd3};
        check("idle_flags", flags, 7'b1000000);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
        check("load_flags", flags, 7'b0010000);
        check("load_alu_a", alu_a, exp_a);
        @(negedge clk);
        check("exec_flags", flags, exp_exec);
        check("exec_alu_b", alu_b, b);
        res_ready = (hold == 0);
        @(negedge clk);
        check("capt_flags", flags, 7'b0000000);
        @(negedge clk);
        check("hold_flags", flags, 7'b0100000);
        check("res_lo", res_lo, exp_lo);
        check("res_hi", res_hi, exp_hi);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            check("bp_flags", flags, 7'b0100000);
            check("bp_res", {res_hi, res_lo}, {exp_hi, exp_lo});
            check("bp_operands", {alu_a, alu_b}, {exp_a, b});
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("retire_flags", flags, 7'b1000000);
        cmd_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a, b;
        int          hold;
        logic [15:0] exp_lo, exp_hi;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] chain;
        logic [15:0] a_eff;
        logic [31:0] r;
        logic [2:0]  op;
        logic [15:0] a, b;

        vecs[0] = '{3'd0, 16'h0005, 16'h0003, 0,  16'h0008, 16'h0000};
        vecs[1] = '{3'd1, 16'h0003, 16'h0005, 0,  16'hFFFE, 16'h0000};
        vecs[2] = '{3'd2, 16'hF0F0, 16'h0FF0, 1,  16'hFF00, 16'h0000};
        vecs[3] = '{3'd3, 16'h0100, 16'h0100, 0,  16'h0000, 16'h0001};
        vecs[4] = '{3'd0, 16'hFFFF, 16'h0001, 10, 16'h0000, 16'h0000};
        vecs[5] = '{3'd3, 16'hFFFF, 16'hFFFF, 2,  16'h0001, 16'hFFFE};
        vecs[6] = '{3'd1, 16'h0000, 16'h0001, 0,  16'hFFFF, 16'h0000};

        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_flags", flags, 7'b1000000);
        check("reset_res", {res_hi, res_lo}, 32'h0);
        check("reset_operands", {alu_a, alu_b}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Reset in EXEC of an ADD abandons it without a result.
        cmd_op = 3'd0; cmd_a = 16'h1234; cmd_b = 16'h0001; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_exec", flags, 7'b0001000);
        rst = 1'b0;
        #1;
        check("midop_reset_flags", flags, 7'b1000000);
        check("midop_reset_operands", {alu_a, alu_b}, 32'h0);
        check("midop_reset_res", {res_hi, res_lo}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_idle", flags, 7'b1000000);
        end
        chain = '0;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].a, vecs[i].hold,
                  vecs[i].exp_lo, vecs[i].exp_hi);
            chain = vecs[i].exp_lo;
        end

        do_op(3'd0, 16'h0002, 16'h0003, 16'h0002, 0, 16'h0005, 16'h0000);
        do_op(3'b100, 16'h7777, 16'h0004, CHAIN ? 16'h0005 : 16'h7777, 0,
              CHAIN ? 16'h0009 : 16'h777B, 16'h0000);
        chain = CHAIN ? 16'h0009 : 16'h777B;

        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom);
            a  = 16'($urandom);
            b  = (n % 8 == 0) ? 16'hFFFF : 16'($urandom);
            a_eff = (CHAIN && op[2]) ? chain : a;
            r = ref_alu(op[1:0], a_eff, b);
            do_op(op, a, b, a_eff, int'($urandom_range(0, 3)), r[15:0], r[31:16]);
            chain = r[15:0];
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
